// File: rtl/nps_outmem_pp.sv
// Ping-pong output memory for the NPS pipeline: the write side fills one bank
// while the CPU reads the previously completed frame from the other.
module nps_outmem_pp #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 300,
  parameter int ADR_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  start,
  input  logic                  set,
  input  logic                  vi,
  input  logic                  fi,
  input  logic [DATA_WIDTH-1:0] datai,
  output logic                  fo,
  input  logic [ADR_WIDTH-1:0]  cpu_adr,
  input  logic                  cpu_rd,
  input  logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  vo,
  output logic                  rdy,
  output logic [ADR_WIDTH-1:0]  frame_len,
  output logic                  ovf
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_t;

  localparam logic [ADR_WIDTH-1:0] DEPTH_W = ADR_WIDTH'(DEPTH);

  state_t                 state, state_nxt;
  logic                   wr_bank, rd_bank;
  logic [ADR_WIDTH-1:0]   wr_ptr;
  logic [1:0]             full;
  logic [ADR_WIDTH-1:0]   len [2];
  logic [DATA_WIDTH-1:0]  mem [2][DEPTH];

  logic                   accept, drop, close, release_bank, rd_hit;
  logic [ADR_WIDTH-1:0]   close_len;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    accept       = 1'b0;
    drop         = 1'b0;
    close        = 1'b0;
    release_bank = 1'b0;
    state_nxt    = state;
    if (!set) begin
      accept       = (state == FILL) && vi && (wr_ptr < DEPTH_W);
      drop         = vi && (((state == FILL) && (wr_ptr == DEPTH_W)) || (state == WAIT_BANK));
      release_bank = cpu_done && full[rd_bank];
    end
    close_len = wr_ptr + ADR_WIDTH'(accept);
    if (!set && (state == FILL) && fi && (close_len != '0))
      close = 1'b1;

    unique case (state)
      IDLE:      if (start) state_nxt = FILL;
      // The bank released by a same-cycle cpu_done is deliberately not seen as free here.
      FILL:      if (close && full[~wr_bank]) state_nxt = WAIT_BANK;
      WAIT_BANK: if (!full[wr_bank]) state_nxt = FILL;
      default:   state_nxt = IDLE;
    endcase
  end

  assign rd_hit    = full[rd_bank] && (cpu_adr < len[rd_bank]);
  assign rdy       = full[rd_bank];
  assign frame_len = full[rd_bank] ? len[rd_bank] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state    <= IDLE;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_ptr   <= '0;
      full     <= '0;
      len[0]   <= '0;
      len[1]   <= '0;
      fo       <= 1'b0;
      vo       <= 1'b0;
      cpu_data <= '0;
      ovf      <= 1'b0;
    end else if (set) begin
      state    <= IDLE;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_ptr   <= '0;
      full     <= '0;
      len[0]   <= '0;
      len[1]   <= '0;
      fo       <= 1'b0;
      vo       <= 1'b0;
      cpu_data <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      fo    <= close;
      vo    <= cpu_rd;
      if (cpu_rd)
        cpu_data <= rd_hit ? mem[rd_bank][cpu_adr] : '0;
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (close) begin
        len[wr_bank]  <= close_len;
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
        wr_ptr        <= '0;
      end
      // Write and read banks differ whenever both fire, so these updates never collide.
      if (release_bank) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (drop)
        ovf <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; contents are only meaningful below len[] of a full bank.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_bank][wr_ptr] <= datai;
  end

endmodule

// File: tb/tb_nps_outmem_pp.sv
// Directed self-checking bench for nps_outmem_pp.
module tb_nps_outmem_pp;

  localparam int DW = 24;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_x, start, set, vi, fi, cpu_rd, cpu_done;
  logic [DW-1:0] datai;
  logic [AW-1:0] cpu_adr;
  logic          fo, vo, rdy, ovf;
  logic [DW-1:0] cpu_data;
  logic [AW-1:0] frame_len;

  int tests_run    = 0;
  int tests_failed = 0;
  int fo_cnt       = 0;

  nps_outmem_pp #(.DATA_WIDTH(DW), .DEPTH(300), .ADR_WIDTH(AW)) dut (
    .clk(clk), .reset_x(reset_x), .start(start), .set(set), .vi(vi), .fi(fi),
    .datai(datai), .fo(fo), .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_done(cpu_done),
    .cpu_data(cpu_data), .vo(vo), .rdy(rdy), .frame_len(frame_len), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fo) fo_cnt <= fo_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic f);
    vi = 1'b1; datai = d; fi = f;
    tick();
    vi = 1'b0; fi = 1'b0;
  endtask

  task automatic send_words(input int base, input int n);
    for (int i = 0; i < n; i++) push(DW'(base + i), 1'b0);
  endtask

  task automatic close_frame();
    fi = 1'b1; tick(); fi = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_done();
    cpu_done = 1'b1; tick(); cpu_done = 1'b0;
  endtask

  task automatic pulse_set();
    set = 1'b1; tick(); set = 1'b0;
  endtask

  task automatic read_word(input int adr, output logic v, output logic [DW-1:0] d);
    cpu_rd = 1'b1; cpu_adr = AW'(adr);
    tick();
    v = vo; d = cpu_data;
    cpu_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset_x = 1'b0; start = 0; set = 0; vi = 0; fi = 0; datai = '0;
    cpu_adr = '0; cpu_rd = 0; cpu_done = 0;
    #12;
    tests_run++; if ({fo, vo, rdy, ovf} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: fo,vo,rdy,ovf=%b expected 0000", {fo, vo, rdy, ovf}); end
    tests_run++; if (cpu_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", cpu_data); end
    tests_run++; if (frame_len !== '0) begin tests_failed++; $display("FAIL reset_len: got %0d expected 0", frame_len); end
    @(negedge clk); reset_x = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    int errs = 0;
    pulse_start();
    send_words(0, 300);
    close_frame();
    tests_run++; if (fo !== 1'b1) begin tests_failed++; $display("FAIL fo_pulse: got %b expected 1", fo); end
    tick();
    tests_run++; if (fo !== 1'b0) begin tests_failed++; $display("FAIL fo_one_cycle: got %b expected 0", fo); end
    tests_run++; if (rdy !== 1'b1 || frame_len !== 9'd300) begin tests_failed++; $display("FAIL full_rdy_len: rdy=%b len=%0d expected 1/300", rdy, frame_len); end
    cpu_rd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cpu_adr = AW'(i);
      tick();
      if (vo !== 1'b1 || cpu_data !== DW'(i)) begin
        errs++;
        if (errs < 5) $display("FAIL b2b_read adr %0d: vo=%b data=%h expected 1/%h", i, vo, cpu_data, DW'(i));
      end
    end
    tests_run++; if (errs != 0) tests_failed++;
    cpu_rd = 1'b0;
    tick();
    tests_run++; if (vo !== 1'b0 || cpu_data !== 24'h00012B) begin tests_failed++; $display("FAIL vo_hold: vo=%b data=%h expected 0/00012b", vo, cpu_data); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL full_ovf: got %b expected 0", ovf); end
    pulse_done();
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL done_rdy: got %b expected 0", rdy); end
  endtask

  task automatic test_two_frames();
    int c0;
    logic v; logic [DW-1:0] d;
    c0 = fo_cnt;
    send_words(0, 10);   close_frame();
    send_words(100, 5);  close_frame();
    tick(); tick();
    tests_run++; if (fo_cnt - c0 != 2) begin tests_failed++; $display("FAIL two_fo: got %0d expected 2", fo_cnt - c0); end
    tests_run++; if (frame_len !== 9'd10) begin tests_failed++; $display("FAIL frame_a_len: got %0d expected 10", frame_len); end
    read_word(9, v, d);
    tests_run++; if (v !== 1'b1 || d !== 24'd9) begin tests_failed++; $display("FAIL frame_a_adr9: vo=%b data=%h expected 1/9", v, d); end
    // Both banks full: a third frame must be dropped entirely.
    c0 = fo_cnt;
    send_words(500, 3); close_frame();
    tick(); tick();
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL drop_ovf: got %b expected 1", ovf); end
    tests_run++; if (fo_cnt != c0) begin tests_failed++; $display("FAIL drop_no_fo: got %0d pulses expected 0", fo_cnt - c0); end
    pulse_done();
    tests_run++; if (frame_len !== 9'd5) begin tests_failed++; $display("FAIL frame_b_len: got %0d expected 5", frame_len); end
    read_word(4, v, d);
    tests_run++; if (d !== 24'd104) begin tests_failed++; $display("FAIL frame_b_adr4: got %h expected 68", d); end
    tick(); tick();
    send_words(200, 3); close_frame();
    tests_run++; if (fo !== 1'b1) begin tests_failed++; $display("FAIL frame_c_fo: got %b expected 1", fo); end
    pulse_done();
    tests_run++; if (rdy !== 1'b1 || frame_len !== 9'd3) begin tests_failed++; $display("FAIL frame_c_len: rdy=%b len=%0d expected 1/3", rdy, frame_len); end
    for (int i = 0; i < 3; i++) begin
      read_word(i, v, d);
      tests_run++; if (d !== DW'(200 + i)) begin tests_failed++; $display("FAIL frame_c_adr%0d: got %h expected %h", i, d, DW'(200 + i)); end
    end
    pulse_done();
  endtask

  task automatic test_set();
    int c0;
    logic v; logic [DW-1:0] d;
    send_words(0, 50);
    pulse_set();
    tests_run++; if (rdy !== 1'b0 || frame_len !== '0 || ovf !== 1'b0) begin tests_failed++; $display("FAIL set_clear: rdy=%b len=%0d ovf=%b expected 0/0/0", rdy, frame_len, ovf); end
    // Idle after set: vi/fi before start leave no trace.
    c0 = fo_cnt;
    send_words(7, 3); close_frame();
    tick(); tick();
    tests_run++; if (fo_cnt != c0 || ovf !== 1'b0 || rdy !== 1'b0) begin tests_failed++; $display("FAIL idle_ignore: fo=%0d ovf=%b rdy=%b expected 0/0/0", fo_cnt - c0, ovf, rdy); end
    pulse_start();
    send_words(16, 4); close_frame();
    tests_run++; if (rdy !== 1'b1 || frame_len !== 9'd4) begin tests_failed++; $display("FAIL set_frame_len: rdy=%b len=%0d expected 1/4", rdy, frame_len); end
    for (int i = 0; i < 4; i++) begin
      read_word(i, v, d);
      tests_run++; if (d !== DW'(16 + i)) begin tests_failed++; $display("FAIL set_frame_adr%0d: got %h expected %h", i, d, DW'(16 + i)); end
    end
    pulse_done();
  endtask

  task automatic test_overflow();
    logic v; logic [DW-1:0] d;
    send_words(0, 302);
    close_frame();
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    tests_run++; if (frame_len !== 9'd300) begin tests_failed++; $display("FAIL ovf_len: got %0d expected 300", frame_len); end
    read_word(299, v, d);
    tests_run++; if (d !== 24'd299) begin tests_failed++; $display("FAIL ovf_adr299: got %h expected 12b", d); end
    read_word(300, v, d);
    tests_run++; if (v !== 1'b1 || d !== '0) begin tests_failed++; $display("FAIL adr_out_of_range: vo=%b data=%h expected 1/0", v, d); end
    pulse_done();
  endtask

  task automatic test_vi_fi_same();
    int c0;
    logic v; logic [DW-1:0] d;
    send_words(40, 7);
    push(24'd47, 1'b1);
    tests_run++; if (fo !== 1'b1 || frame_len !== 9'd8) begin tests_failed++; $display("FAIL vifi_len: fo=%b len=%0d expected 1/8", fo, frame_len); end
    read_word(7, v, d);
    tests_run++; if (d !== 24'd47) begin tests_failed++; $display("FAIL vifi_adr7: got %h expected 2f", d); end
    c0 = fo_cnt;
    close_frame();
    tick(); tick();
    tests_run++; if (fo_cnt != c0) begin tests_failed++; $display("FAIL empty_fi: got %0d pulses expected 0", fo_cnt - c0); end
    pulse_done();
  endtask

  task automatic test_async_reset();
    logic v; logic [DW-1:0] d;
    pulse_set();
    pulse_start();
    push(24'h000055, 1'b0);
    push(24'h0000AA, 1'b0);
    close_frame();
    read_word(1, v, d);
    tests_run++; if (v !== 1'b1 || d !== 24'h0000AA) begin tests_failed++; $display("FAIL pre_reset_read: vo=%b data=%h expected 1/aa", v, d); end
    cpu_rd = 1'b1; cpu_adr = 9'd1;
    tick();
    #2 reset_x = 1'b0;
    #1;
    tests_run++; if ({vo, fo, rdy} !== 3'b000 || cpu_data !== '0) begin tests_failed++; $display("FAIL async_reset: vo,fo,rdy=%b data=%h expected 000/0", {vo, fo, rdy}, cpu_data); end
    cpu_rd = 1'b0;
    @(negedge clk); reset_x = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_two_frames();
    test_set();
    test_overflow();
    test_vi_fi_same();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nps_outmem_pp.md
Name: nps_outmem_pp

Overview:
Double-buffered (ping-pong) successor to NPS_outmem. It captures a valid-qualified result stream from the NPS pipeline into one of two banks while the CPU reads the previously completed frame from the other bank. Frame length and depth are parametrised, each bank records its own frame length, and an overflow/drop condition is flagged. It sits at the tail of the NPS pipeline, between the last processing stage and the CPU read interface.

Parameters:
DATA_WIDTH, 24, width of datai / cpu_data
DEPTH, 300, words per bank (maximum frame length)
ADR_WIDTH, 9, width of cpu_adr and of frame_len; requires 2^ADR_WIDTH > DEPTH

Ports:
clk  in  1  clock; all logic on rising edge
reset_x  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; arms capture (IDLE->FILL)
set  in  1  synchronous soft clear; highest priority after reset
vi  in  1  datai valid
fi  in  1  1-cycle frame-end pulse
datai  in  DATA_WIDTH  stream data
fo  out  1  1-cycle pulse: a frame has become readable
cpu_adr  in  ADR_WIDTH  CPU read word address within read bank
cpu_rd  in  1  CPU read strobe
cpu_done  in  1  1-cycle pulse: CPU releases read bank
cpu_data  out  DATA_WIDTH  registered read data
vo  out  1  cpu_data valid, 1 cycle after cpu_rd
rdy  out  1  read bank holds a complete frame
frame_len  out  ADR_WIDTH  word count of read bank frame
ovf  out  1  sticky: data dropped

Behaviour:
- Reset (reset_x=0, async): all outputs 0; wr_bank=rd_bank=0; wr_ptr=0; both full flags 0; lengths 0; FSM=IDLE. Memory contents need not be cleared.
- set=1 (sync): same state as reset except memory; overrides start/vi/fi/cpu_* in that cycle.
- Write FSM states: IDLE, FILL, WAIT_BANK.
- IDLE: vi and fi ignored (no ovf). start -> FILL.
- FILL, vi=1:
  - wr_ptr<DEPTH: mem[wr_bank][wr_ptr]<=datai; wr_ptr++.
  - wr_ptr==DEPTH: word dropped; ovf<=1.
- FILL, fi=1:
  - Same-cycle vi is written first. Closed length L = wr_ptr + (accepted vi ? 1 : 0).
  - L==0: fi ignored.
  - Otherwise len[wr_bank]<=L; full[wr_bank]<=1; fo=1 next cycle, for exactly 1 cycle; wr_bank toggles; wr_ptr<=0.
  - Next state: FILL if the new wr_bank is not full, else WAIT_BANK.
- WAIT_BANK: vi -> dropped, ovf<=1. fi ignored. When full[wr_bank] clears (cpu_done), -> FILL on the following cycle.
- Read side:
  - cpu_rd=1: next cycle cpu_data<=mem[rd_bank][cpu_adr] and vo=1. cpu_data=0 when cpu_adr>=len[rd_bank] or full[rd_bank]=0.
  - vo=0 in all other cycles; cpu_data holds its last value.
  - Back-to-back cpu_rd gives one word per cycle.
- rdy=full[rd_bank]; frame_len=len[rd_bank] (0 when not full). Both combinational from registers.
- cpu_done with rdy=1: full[rd_bank]<=0; rd_bank toggles. cpu_done with rdy=0: ignored.
- cpu_done and fi in the same cycle: both take effect. A bank freed this cycle is not seen as free by the fi decision; the FSM may enter WAIT_BANK and leave it the next cycle.
- cpu_rd and cpu_done in the same cycle: the read uses the old rd_bank.
- Frame order is preserved: banks are read in the order they were filled. At most 2 frames are pending.
- ovf clears only on reset or set.

Test Plan:
- Reset, start, 300 vi words datai=i, fi -> fo pulse 1 cycle; rdy=1; frame_len=300; cpu_rd adr 0..299 returns 0x000000..0x00012B, each with vo 1 cycle later; ovf=0.
- Frame A 10 words (0..9) plus fi, then frame B 5 words (100..104) plus fi, no cpu_done -> two fo pulses; read bank A len 10; cpu_done -> frame_len=5, adr 4 reads 104.
- Third frame while both banks full -> vi dropped, ovf=1, no third fo; cpu_done -> FILL; a new frame of 3 words reads back correctly after the next cpu_done.
- 302 vi words then fi -> ovf=1; frame_len=300; adr 299 = 299; cpu_rd at adr 300 -> cpu_data=0.
- vi and fi same cycle on word 7 (8th word) -> frame_len=8, adr 7 correct; fi alone with empty frame -> no fo. vi before start -> ignored, ovf=0.
- set mid-frame after 50 words -> rdy=0, frame_len=0, ovf=0, FSM idle; start plus 4-word frame -> reads from bank 0 correctly. reset_x low mid-read -> vo, fo, cpu_data, rdy all 0 immediately.
